// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: shift sequencer states, direction codes and
// the two-bit command encoding understood by the single-bit shift stage.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // bit0 = shift this cycle, bit1 = direction
    typedef enum logic [1:0] {
        SE_NONE  = 2'b00,
        SE_LEFT  = 2'b01,
        SE_RIGHT = 2'b11
    } shift_en_e;

    function automatic shift_en_e shift_cmd(input logic dir);
        return (dir == DIR_RIGHT) ? SE_RIGHT : SE_LEFT;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift; reports the bit pushed off the end.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             dir_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] value_o,
    output logic             carry_o
);

    always_comb begin
        if (dir_i == DIR_RIGHT) begin
            value_o = {fill_i, value_i[WIDTH-1:1]};
            carry_o = value_i[0];
        end else begin
            value_o = {value_i[WIDTH-2:0], 1'b0};
            carry_o = value_i[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Multi-bit shift sequencer: accepts a request, shifts one position per clock,
// and returns the result plus last carry over a valid/ready handshake.
module shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] operand,
    input  logic             dir,
    input  logic             arith,
    input  logic [AMT_W-1:0] amount,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             busy,
    output logic [1:0]       shift_enable
);

    localparam logic [AMT_W-1:0] MAX_CNT = AMT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             arith_q, arith_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    logic [AMT_W-1:0] sat_amount;
    logic [WIDTH-1:0] step_value;
    logic             step_carry;

    assign sat_amount = (amount > MAX_CNT) ? MAX_CNT : amount;

    // Arithmetic right shifts replicate the current MSB, which never changes
    // while shifting right, so it stays equal to the original sign bit.
    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value_i(work_q),
        .dir_i  (dir_q),
        .fill_i (arith_q & work_q[WIDTH-1]),
        .value_o(step_value),
        .carry_o(step_carry)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    work_d  = operand;
                    dir_d   = dir;
                    arith_d = arith;
                    cnt_d   = sat_amount;
                    carry_d = 1'b0;
                    state_d = (sat_amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_d  = step_value;
                carry_d = step_carry;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
            arith_q <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign start_ready  = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign shift_enable = (state_q == SHIFT) ? shift_cmd(dir_q) : SE_NONE;
    assign result       = work_q;
    assign carry_out    = carry_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: a behavioural shift model queues expected
// results at request time; they are popped and compared when the DUT responds.
module tb_shift_seq;

    logic       clk;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] operand;
    logic       dir;
    logic       arith;
    logic [3:0] amount;
    logic [7:0] result;
    logic       carry_out;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
    logic [1:0] shift_enable;

    typedef struct {
        logic [7:0] res;
        logic       carry;
        int         k;
        logic       d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    shift_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .operand     (operand),
        .dir         (dir),
        .arith       (arith),
        .amount      (amount),
        .result      (result),
        .carry_out   (carry_out),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy        (busy),
        .shift_enable(shift_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] op, input logic d, input logic a,
                                   input logic [3:0] amt);
        exp_t e;
        logic [7:0] v;
        logic c;
        int k;
        v = op;
        c = 1'b0;
        k = (amt > 4'd8) ? 8 : int'(amt);
        for (int i = 0; i < k; i++) begin
            if (!d) begin
                c = v[7];
                v = {v[6:0], 1'b0};
            end else begin
                c = v[0];
                v = {a & op[7], v[7:1]};
            end
        end
        e.res = v;
        e.carry = c;
        e.k = k;
        e.d = d;
        return e;
    endfunction

    // Called at a negedge with the DUT idle; returns at the first negedge after the accept edge.
    task automatic send_req(input logic [7:0] op, input logic d, input logic a, input logic [3:0] amt);
        operand = op;
        dir = d;
        arith = a;
        amount = amt;
        start_valid = 1'b1;
        sb.push_back(model(op, d, a, amt));
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int se_cnt, output logic [1:0] se_val);
        lat = 1;
        se_cnt = 0;
        se_val = 2'b00;
        while (!result_valid && lat < 40) begin
            if (shift_enable[0]) begin
                se_cnt++;
                se_val = shift_enable;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        operand = '0;
        dir = 1'b0;
        arith = 1'b0;
        amount = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_ready, busy, result_valid, result, carry_out, shift_enable} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00}) begin
            failures++;
            $display("[TB] FAIL reset_state: got rdy=%b busy=%b vld=%b res=%h c=%b se=%b, want rdy=1 busy=0 vld=0 res=00 c=0 se=00",
                     start_ready, busy, result_valid, result, carry_out, shift_enable);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_shifts();
        logic [7:0] ops[6]  = '{8'h81, 8'h80, 8'h80, 8'h5A, 8'hFF, 8'h96};
        logic       dirs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       ars[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0] amts[6] = '{4'd1, 4'd7, 4'd3, 4'd0, 4'd12, 4'd15};
        int lat, se_cnt;
        logic [1:0] se_val;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            send_req(ops[i], dirs[i], ars[i], amts[i]);
            wait_valid(lat, se_cnt, se_val);
            e = sb.pop_front();
            checks++;
            if (result_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL basic%0d_timeout: result_valid=%b after %0d cycles, want 1", i, result_valid, lat);
            end
            checks++;
            if (lat !== e.k + 1) begin
                failures++;
                $display("[TB] FAIL basic%0d_latency: got %0d cycles, want %0d", i, lat, e.k + 1);
            end
            checks++;
            if (result !== e.res || carry_out !== e.carry) begin
                failures++;
                $display("[TB] FAIL basic%0d_result: got %h/%b, want %h/%b", i, result, carry_out, e.res, e.carry);
            end
            checks++;
            if (se_cnt !== e.k) begin
                failures++;
                $display("[TB] FAIL basic%0d_se_count: got %0d shift cycles, want %0d", i, se_cnt, e.k);
            end
            if (e.k > 0) begin
                checks++;
                if (se_val !== {e.d, 1'b1}) begin
                    failures++;
                    $display("[TB] FAIL basic%0d_se_code: got %b, want %b", i, se_val, {e.d, 1'b1});
                end
            end
            consume();
            checks++;
            if (start_ready !== 1'b1 || result_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL basic%0d_handshake: rdy=%b vld=%b, want rdy=1 vld=0", i, start_ready, result_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat, se_cnt;
        logic [1:0] se_val;
        exp_t e;
        send_req(8'h3C, 1'b0, 1'b0, 4'd2);
        wait_valid(lat, se_cnt, se_val);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result !== e.res || carry_out !== e.carry || busy !== 1'b1) begin
                failures++;
                $display("[TB] FAIL backpressure_hold%0d: vld=%b res=%h c=%b busy=%b, want 1/%h/%b/1",
                         i, result_valid, result, carry_out, busy, e.res, e.carry);
            end
            @(negedge clk);
        end
        consume();
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL backpressure_release: rdy=%b busy=%b, want 1/0", start_ready, busy);
        end
    endtask

    task automatic test_ignored_start();
        int lat, se_cnt;
        logic [1:0] se_val;
        exp_t e;
        send_req(8'hA5, 1'b1, 1'b0, 4'd6);
        checks++;
        if (busy !== 1'b1 || start_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL shift_busy: busy=%b rdy=%b, want 1/0", busy, start_ready);
        end
        operand = 8'h00;
        amount = 4'd0;
        start_valid = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        result_ready = 1'b0;
        wait_valid(lat, se_cnt, se_val);
        e = sb.pop_front();
        checks++;
        if (result_valid !== 1'b1 || result !== e.res || carry_out !== e.carry) begin
            failures++;
            $display("[TB] FAIL ignored_start_result: vld=%b res=%h c=%b, want 1/%h/%b",
                     result_valid, result, carry_out, e.res, e.carry);
        end
        consume();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignored_start_queued: busy=%b vld=%b, want 0/0", busy, result_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat, se_cnt;
        logic [1:0] se_val;
        exp_t e;
        send_req(8'h01, 1'b0, 1'b0, 4'd7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({start_ready, busy, result_valid, result, carry_out, shift_enable} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 2'b00}) begin
            failures++;
            $display("[TB] FAIL reset_mid: got rdy=%b busy=%b vld=%b res=%h c=%b se=%b, want 1/0/0/00/0/00",
                     start_ready, busy, result_valid, result, carry_out, shift_enable);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_req(8'h01, 1'b0, 1'b0, 4'd1);
        wait_valid(lat, se_cnt, se_val);
        e = sb.pop_front();
        checks++;
        if (result_valid !== 1'b1 || result !== 8'h02 || carry_out !== 1'b0 || result !== e.res) begin
            failures++;
            $display("[TB] FAIL reset_recover: vld=%b res=%h c=%b, want 1/02/0", result_valid, result, carry_out);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic_shifts();
        test_backpressure();
        test_ignored_start();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
